// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the 2x2 systolic matrix multiplier and its control
// logic. It provides the default element widths, the controller state
// encoding, operand and result matrix types, and small helpers for the
// row/column skew used when streaming operands into the array.
// -----------------------------------------------------------------------------
package tpu_pkg;

  // Default operand element width and accumulator/result element width.
  localparam int TPU_DW = 8;
  localparam int TPU_AW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } mmu_ctrl_state_t;

  // Matrix element [r][c] sits at index [r][c]. Element [1][1] occupies the
  // most significant slice.
  typedef logic [1:0][1:0][TPU_DW-1:0] operand_mat_t;
  typedef logic [1:0][1:0][TPU_AW-1:0] result_mat_t;
  typedef logic [1:0][TPU_DW-1:0]      operand_vec_t;

  // Lane `lane` carries a real element on feed step `step` only when
  // 0 <= step - lane <= 1. Outside that window the lane carries zero.
  function automatic logic skew_hit(input logic [1:0] step, input int lane);
    return (int'(step) >= lane) && ((int'(step) - lane) <= 1);
  endfunction

  // Inner index (step - lane) of the element a lane carries. This value is
  // meaningful only when skew_hit() is true.
  function automatic logic skew_sel(input logic [1:0] step, input int lane);
    return 1'(int'(step) - lane);
  endfunction

endpackage : tpu_pkg

// File: rtl/mmu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mmu_ctrl_if
// Bundles the signals around mmu_ctrl: the host operand write port, the run
// control/status, the streams into the systolic array, the result coming
// back from the array, and the result handshake toward the host.
//
// Modports:
//   slave  - the controller's view (mmu_ctrl)
//   master - the surrounding system's view (host plus array)
//
// Signals:
//   ld_valid/ld_ready/ld_sel/ld_idx/ld_data  operand element write port
//   start/busy/timeout                       run control and status
//   mmu_clr/mmu_a/mmu_b/mmu_valid            streams into the array
//   mmu_valid_out/mmu_c                      array completion and result
//   res_valid/res_ready/res_c                captured result handshake
// -----------------------------------------------------------------------------
interface mmu_ctrl_if #(
  parameter int DW = tpu_pkg::TPU_DW,
  parameter int AW = tpu_pkg::TPU_AW
) ();

  logic                      ld_valid;
  logic                      ld_ready;
  logic                      ld_sel;
  logic [1:0]                ld_idx;
  logic [DW-1:0]             ld_data;

  logic                      start;
  logic                      busy;
  logic                      timeout;

  logic                      mmu_clr;
  logic [1:0][DW-1:0]        mmu_a;
  logic [1:0][DW-1:0]        mmu_b;
  logic                      mmu_valid;
  logic                      mmu_valid_out;
  logic [1:0][1:0][AW-1:0]   mmu_c;

  logic                      res_valid;
  logic                      res_ready;
  logic [1:0][1:0][AW-1:0]   res_c;

  modport slave (
    input  ld_valid, ld_sel, ld_idx, ld_data,
    output ld_ready,
    input  start,
    output busy, timeout,
    output mmu_clr, mmu_a, mmu_b, mmu_valid,
    input  mmu_valid_out, mmu_c,
    output res_valid, res_c,
    input  res_ready
  );

  modport master (
    output ld_valid, ld_sel, ld_idx, ld_data,
    input  ld_ready,
    output start,
    input  busy, timeout,
    input  mmu_clr, mmu_a, mmu_b, mmu_valid,
    output mmu_valid_out, mmu_c,
    input  res_valid, res_c,
    output res_ready
  );

endinterface : mmu_ctrl_if

// File: rtl/mmu_operand_rf.sv
// -----------------------------------------------------------------------------
// mmu_operand_rf
// Stores the two 2x2 operand matrices A and B and an 8-bit mask that records
// which elements have been written. Stored contents persist until reset, so
// a later run can reuse the same operands.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset; clears both matrices and the mask
//   we     write enable
//   sel    0 = matrix A, 1 = matrix B
//   idx    element index = row*2 + col
//   data   element value
//   a_mat  matrix A, element [r][c]
//   b_mat  matrix B, element [r][c]
//   full   high when all eight elements have been written
// -----------------------------------------------------------------------------
module mmu_operand_rf
  import tpu_pkg::*;
#(
  parameter int DW = TPU_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    sel,
  input  logic [1:0]              idx,
  input  logic [DW-1:0]           data,
  output logic [1:0][1:0][DW-1:0] a_mat,
  output logic [1:0][1:0][DW-1:0] b_mat,
  output logic                    full
);

  // Bit {sel, idx} is set once that element has been written.
  logic [7:0] mask_q;

  // NOTE: This storage holds only eight elements. A start with a partly
  // loaded store must be rejected after reset, so the contents are reset
  // together with the mask. Large RAMs usually leave contents unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mat  <= '0;
      b_mat  <= '0;
      mask_q <= '0;
    end else if (we) begin
      if (sel) b_mat[idx[1]][idx[0]] <= data;
      else     a_mat[idx[1]][idx[0]] <= data;
      mask_q[{sel, idx}] <= 1'b1;
    end
  end

  // This flag comes from the registered mask, so a write in the same cycle
  // as start is not yet visible when start is evaluated.
  assign full = &mask_q;

endmodule : mmu_operand_rf

// File: rtl/mmu_ctrl.sv
// -----------------------------------------------------------------------------
// mmu_ctrl
// Operand sequencer and result collector for the 2x2 systolic multiplier.
// The controller collects A and B through the write port. On start it sends
// a one-cycle clear to the array and streams the skewed rows of A and the
// skewed columns of B over three feed steps. It then waits, for a bounded
// number of cycles, for the array's completion strobe. The captured result
// is held behind a valid/ready handshake.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset; aborts any run
//   bus   mmu_ctrl_if.slave:
//           ld_*          operand write port; ld_ready is high only in IDLE
//           start         begin a run; ignored unless IDLE and all 8 loaded
//           busy          state is not IDLE
//           timeout       sticky abort flag; cleared by the next accepted start
//           mmu_clr       one-cycle accumulator clear
//           mmu_a/mmu_b   skewed row/column streams into the array
//           mmu_valid     array valid_in, high on the first feed step only
//           mmu_valid_out array completion strobe; used only in WAIT
//           mmu_c         array result
//           res_valid/res_ready/res_c  captured result handshake
//
// Parameters: DW operand width, AW result width, TIMEOUT maximum WAIT cycles.
// -----------------------------------------------------------------------------
module mmu_ctrl
  import tpu_pkg::*;
#(
  parameter int DW      = TPU_DW,
  parameter int AW      = TPU_AW,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  mmu_ctrl_if.slave  bus
);

  // The counter only needs to hold 0 .. TIMEOUT-1, because the run leaves
  // WAIT on that last value.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  mmu_ctrl_state_t         state_q, state_n;
  logic [1:0]              step_q, step_n;
  logic [CW-1:0]           wait_q, wait_n;
  logic                    timeout_q, timeout_n;
  logic                    clr_q, clr_n;
  logic                    valid_q, valid_n;
  logic [1:0][DW-1:0]      a_q, a_n;
  logic [1:0][DW-1:0]      b_q, b_n;
  logic                    res_valid_q, res_valid_n;
  logic [1:0][1:0][AW-1:0] res_c_q, res_c_n;

  logic                    idle;
  logic                    full;
  logic [1:0][1:0][DW-1:0] a_mat;
  logic [1:0][1:0][DW-1:0] b_mat;

  assign idle = (state_q == IDLE);

  mmu_operand_rf #(.DW(DW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.ld_valid && idle),
    .sel   (bus.ld_sel),
    .idx   (bus.ld_idx),
    .data  (bus.ld_data),
    .a_mat (a_mat),
    .b_mat (b_mat),
    .full  (full)
  );

  // Next state, and the next value of each registered output. The outputs
  // are computed from the next state so that each one is valid in the same
  // cycle as the state it belongs to.
  // NOTE: Every signal is given its default before the case statement.
  // This lets a branch assign only the signals it changes, and no signal
  // is left unassigned on any path, so no latches are inferred.
  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    wait_n    = wait_q;
    timeout_n = timeout_q;
    res_c_n   = res_c_q;

    case (state_q)
      IDLE: begin
        if (bus.start && full) begin
          state_n   = CLEAR;
          timeout_n = 1'b0;
        end
      end
      CLEAR: begin
        state_n = FEED;
        step_n  = 2'd0;
      end
      FEED: begin
        if (step_q == 2'd2) begin
          state_n = WAIT;
          wait_n  = '0;
        end else begin
          step_n = step_q + 2'd1;
        end
      end
      WAIT: begin
        wait_n = wait_q + CW'(1);
        // A strobe takes priority, including in the last allowed cycle.
        if (bus.mmu_valid_out) begin
          res_c_n = bus.mmu_c;
          state_n = HOLD;
        end else if (wait_q == WAIT_LAST) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      HOLD: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    clr_n       = (state_n == CLEAR);
    valid_n     = (state_n == FEED) && (step_n == 2'd0);
    res_valid_n = (state_n == HOLD);

    a_n = '0;
    b_n = '0;
    if (state_n == FEED) begin
      for (int lane = 0; lane < 2; lane++) begin
        if (skew_hit(step_n, lane)) begin
          a_n[lane] = a_mat[lane][skew_sel(step_n, lane)];
          b_n[lane] = b_mat[skew_sel(step_n, lane)][lane];
        end
      end
    end
  end

  // NOTE: State is updated with non-blocking assignments. All registers
  // then sample their inputs at the same edge, and the order of the
  // statements does not change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      clr_q       <= 1'b0;
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
    end else begin
      state_q     <= state_n;
      step_q      <= step_n;
      wait_q      <= wait_n;
      timeout_q   <= timeout_n;
      clr_q       <= clr_n;
      valid_q     <= valid_n;
      a_q         <= a_n;
      b_q         <= b_n;
      res_valid_q <= res_valid_n;
      res_c_q     <= res_c_n;
    end
  end

  assign bus.ld_ready  = idle;
  assign bus.busy      = !idle;
  assign bus.timeout   = timeout_q;
  assign bus.mmu_clr   = clr_q;
  assign bus.mmu_a     = a_q;
  assign bus.mmu_b     = b_q;
  assign bus.mmu_valid = valid_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_c     = res_c_q;

endmodule : mmu_ctrl

// File: doc/mmu_ctrl.md
# mmu_ctrl

Operand sequencer and result collector for the 2x2 systolic matrix multiplier (`mmu`). It accepts the elements of two 2x2 operand matrices A and B through a write port, clears the multiplier, and drives the skewed row/column streams into the array. It then waits for the array's completion strobe, captures the 2x2 result, and holds it behind a valid/ready handshake. It sits between the host/DMA side and `mmu`, at the transmitting end of the `mmu` `a_in`/`b_in`/`valid_in` interface and the receiving end of its `c_out`/`valid_out` interface.

## Interface
Parameters:
- DW, 8, operand element width
- AW, 16, accumulator/result element width
- TIMEOUT, 15, maximum cycles spent in WAIT before abort (≥1)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  operand element write strobe
- ld_ready  out  1  high iff state is IDLE
- ld_sel  in  1  0 = matrix A, 1 = matrix B
- ld_idx  in  2  element index = row*2 + col
- ld_data  in  DW  element value
- start  in  1  begin a multiply; acted on only in IDLE with all 8 elements loaded
- busy  out  1  high iff state is not IDLE
- timeout  out  1  sticky abort flag; cleared by the next accepted start or by rst
- mmu_clr  out  1  one-cycle accumulator clear pulse to the array
- mmu_a  out  2×DW  row stream: mmu_a[i] feeds array row i
- mmu_b  out  2×DW  column stream: mmu_b[j] feeds array column j
- mmu_valid  out  1  array valid_in
- mmu_valid_out  in  1  array completion strobe
- mmu_c  in  2×2×AW  array result
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_c  out  2×2×AW  captured result

## Operation
- Operand store: A[2][2] and B[2][2] of DW bits each, plus an 8-bit loaded mask.
- A write occurs when ld_valid && ld_ready. The write stores ld_data and sets the mask bit {ld_sel, ld_idx}. Rewriting an element overwrites it.
- Operands and mask persist across runs; only rst clears them. A repeated start re-runs the same operands.
- start in IDLE with the mask ≠ 8'hFF is ignored (no state change, no flag).
- If ld_valid and start are both asserted in the same IDLE cycle, the write happens and start is evaluated against the mask as it stood before that write.
- FSM states:
  - IDLE: start accepted → CLEAR; timeout cleared.
  - CLEAR: mmu_clr = 1 for one cycle → FEED, with step = 0.
  - FEED: lasts three cycles, step = 0, 1, 2.
    - mmu_a[i] = A[i][step−i] when 0 ≤ step−i ≤ 1, else 0.
    - mmu_b[j] = B[step−j][j] when 0 ≤ step−j ≤ 1, else 0.
    - mmu_valid = 1 on step 0 only.
    - After step 2 → WAIT, with the wait counter cleared.
  - WAIT: the counter increments each cycle.
    - mmu_valid_out = 1 → res_c ← mmu_c, then HOLD.
    - Counter reaches TIMEOUT with no strobe → timeout = 1, then IDLE; res_valid stays 0.
  - HOLD: res_valid = 1 and res_c stable until res_valid && res_ready, then IDLE.
- mmu_valid_out outside WAIT is ignored. A strobe in the same cycle the counter hits TIMEOUT counts as success.
- mmu_a, mmu_b and mmu_valid are 0 outside FEED.
- Result is stored at full AW width, with no truncation or saturation.

## Timing
- All outputs are registered except ld_ready and busy, which decode the state register.
- Reset values:
  - State IDLE, so ld_ready = 1 and busy = 0.
  - timeout = 0, mmu_clr = 0, mmu_valid = 0.
  - mmu_a = mmu_b = 0.
  - res_valid = 0, res_c = 0.
  - Operand store and mask = 0.
- Schedule for start accepted at cycle N:
  - mmu_clr at N+1.
  - FEED steps 0, 1, 2 at N+2, N+3, N+4; mmu_valid at N+2.
  - WAIT from N+5.
  - Strobe seen at cycle M → res_valid from M+1.
- res_ready at the first res_valid cycle gives a back-to-back return: IDLE at M+2, and a start then is accepted.
- rst asserted in any state returns everything to the reset values on the next edge and aborts the in-flight run.

## Structure
- Shared package `tpu_pkg`:
  - DW and AW defaults.
  - `mmu_ctrl_state_t` enum (IDLE, CLEAR, FEED, WAIT, HOLD).
  - Operand matrix and result matrix typedefs.
- Sub-module `mmu_operand_rf`: the 8-entry operand store plus loaded mask, with write port and full-mask output.
- FSM, skew generation and result capture live in `mmu_ctrl`.

## Test plan
- Load A = [[1,2],[3,4]] and B = [[5,6],[7,8]], then start:
  - mmu_clr one cycle.
  - Feed (a0,a1 | b0,b1) = (1,0 | 5,0), (2,3 | 7,6), (0,4 | 0,8).
  - mmu_valid only on the first feed step.
- Same run with mmu_c = [[19,22],[43,50]] and the strobe 5 cycles into WAIT → res_c = [[19,22],[43,50]]. res_valid holds while res_ready = 0 for 4 cycles, then IDLE one cycle after the handshake.
- Load only 7 elements, then start → busy stays 0. Write the 8th element, then start → accepted.
- No mmu_valid_out → timeout = 1 after TIMEOUT = 15 WAIT cycles, res_valid never asserts. The next start clears timeout.
- Strobe in the exact cycle the counter reaches TIMEOUT → success, timeout stays 0. Strobe during FEED → ignored.
- rst pulsed during FEED step 1 → all outputs at reset values next cycle. A subsequent start is ignored because the mask was cleared.
